// File: rtl/vslc_scan_scheduler.sv
// Scan-cycle sequencer for the VSLC core: stop, free-run or single-step triggering,
// with overrun detection, a scan watchdog that latches a fault, and a wrapping scan counter.
module vslc_scan_scheduler #(
  parameter int unsigned         PERIOD_W   = 24,
  parameter logic [PERIOD_W-1:0] DEF_PERIOD = 24'd12000,
  parameter int unsigned         WDOG_W     = 16,
  parameter logic [WDOG_W-1:0]   WDOG_LIMIT = 16'hFFFF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          mode_i,
  input  logic                step_req_i,
  input  logic                period_load_i,
  input  logic [PERIOD_W-1:0] period_in_i,
  input  logic                scan_done_i,
  input  logic                scan_busy_i,
  input  logic                clr_i,
  output logic                scan_trigger_o,
  output logic                overrun_o,
  output logic                fault_o,
  output logic [15:0]         scan_count_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_TRIGGER   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam logic [PERIOD_W-1:0] P_ZERO    = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] P_ONE     = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0]   W_ZERO    = {WDOG_W{1'b0}};
  localparam logic [WDOG_W-1:0]   W_ONE     = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0]   W_MAX     = {WDOG_W{1'b1}};
  localparam logic [1:0]          MODE_FREE = 2'd1;
  localparam logic [1:0]          MODE_STEP = 2'd2;

  // A period of 0 behaves as 1, so the reload value never underflows.
  function automatic logic [PERIOD_W-1:0] reload_of(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] r;
    if (p == P_ZERO) begin
      r = P_ZERO;
    end else begin
      r = p - P_ONE;
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                trig_q, trig_d;
  logic                fault_q, fault_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         scan_count_q, scan_count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                counting_s;
  logic                tick_s;
  logic                busy_unused_s;

  assign busy_unused_s = scan_busy_i;

  // Next-state logic: FSM, watchdog, scan counter, period counter and overrun flag.
  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    scan_count_d = scan_count_q;
    overrun_d    = overrun_q;
    period_d     = period_q;
    pcnt_d       = pcnt_q;
    counting_s   = (mode_i == MODE_FREE) && (state_q != ST_FAULT);
    tick_s       = counting_s && (pcnt_q == P_ZERO);

    case (state_q)
      ST_IDLE: begin
        if (mode_i == MODE_FREE) begin
          state_d = ST_WAIT_TICK;
        end else if ((mode_i == MODE_STEP) && step_req_i) begin
          state_d = ST_TRIGGER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_TICK: begin
        if (mode_i != MODE_FREE) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          state_d = ST_TRIGGER;
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_TRIGGER: begin
        state_d = ST_RUN;
        wdog_d  = W_ZERO;
      end
      ST_RUN: begin
        wdog_d = (wdog_q == W_MAX) ? wdog_q : wdog_q + W_ONE;
        // A done arriving on the expiry cycle still counts as a good scan.
        if (scan_done_i) begin
          scan_count_d = scan_count_q + 16'd1;
          state_d      = (mode_i == MODE_FREE) ? ST_WAIT_TICK : ST_IDLE;
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (clr_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (period_load_i) begin
      period_d = period_in_i;
      pcnt_d   = reload_of(period_in_i);
    end else if (!counting_s || tick_s) begin
      pcnt_d = reload_of(period_q);
    end else begin
      pcnt_d = pcnt_q - P_ONE;
    end

    // Ticks during an outstanding scan are dropped and flagged; set beats clear.
    if (tick_s && ((state_q == ST_TRIGGER) || (state_q == ST_RUN))) begin
      overrun_d = 1'b1;
    end else if (clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    trig_d  = (state_d == ST_TRIGGER);
    fault_d = (state_d == ST_FAULT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      trig_q       <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
      scan_count_q <= 16'd0;
      period_q     <= DEF_PERIOD;
      pcnt_q       <= reload_of(DEF_PERIOD);
      wdog_q       <= W_ZERO;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      fault_q      <= fault_d;
      overrun_q    <= overrun_d;
      scan_count_q <= scan_count_d;
      period_q     <= period_d;
      pcnt_q       <= pcnt_d;
      wdog_q       <= wdog_d;
    end
  end

  assign scan_trigger_o = trig_q;
  assign overrun_o      = overrun_q;
  assign fault_o        = fault_q;
  assign scan_count_o   = scan_count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_vslc_scan_scheduler.sv
// Self-checking bench for vslc_scan_scheduler: table-driven single-step vectors plus
// hand-written free-run, overrun, watchdog, zero-period, wrap and reset sequences.
module tb_vslc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        step_req = 1'b0;
  logic        period_load = 1'b0;
  logic [23:0] period_in = 24'd0;
  logic        auto_done = 1'b0;
  logic        man_done = 1'b0;
  logic        scan_done;
  logic        scan_busy = 1'b0;
  logic        clr = 1'b0;
  logic        scan_trigger_o;
  logic        overrun_o;
  logic        fault_o;
  logic [15:0] scan_count_o;
  logic [2:0]  state_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cd = 0;
  int core_delay = 0;
  int c0 = 0;
  int trig_q[$];

  assign scan_done = auto_done | man_done;

  always #5 clk = ~clk;

  vslc_scan_scheduler #(
    .PERIOD_W(24), .DEF_PERIOD(24'd12000), .WDOG_W(16), .WDOG_LIMIT(16'd8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .step_req_i(step_req),
    .period_load_i(period_load), .period_in_i(period_in), .scan_done_i(scan_done),
    .scan_busy_i(scan_busy), .clr_i(clr), .scan_trigger_o(scan_trigger_o),
    .overrun_o(overrun_o), .fault_o(fault_o), .scan_count_o(scan_count_o),
    .state_o(state_o)
  );

  // Core model and trigger monitor: samples 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    auto_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) auto_done = 1'b1;
    end
    if (scan_trigger_o) begin
      trig_q.push_back(cyc);
      if (core_delay > 0) cd = core_delay;
    end
    scan_busy = (cd > 0);
  end

  typedef struct {
    logic [1:0]  mode;
    logic        step;
    logic        done;
    logic        clr;
    logic [2:0]  st;
    logic        trig;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt [11];

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_trig(input int n, input int budget, input string nm);
    int b = budget;
    while (trig_q.size() < n && b > 0) begin
      tick_n(1);
      b--;
    end
    if (trig_q.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d triggers, expected %0d", nm, trig_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode = 2'd0; step_req = 1'b0; period_load = 1'b0; period_in = 24'd0;
    man_done = 1'b0; clr = 1'b0; core_delay = 0; cd = 0;
    tick_n(2);
    trig_q.delete();
    rst = 1'b0;
  endtask

  task automatic load_and_run(input logic [23:0] p, input int dly);
    period_in = p; period_load = 1'b1; mode = 2'd1; core_delay = dly;
    c0 = cyc;
    tick_n(1);
    period_load = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          mode  step  done  clr   state trig  count
    vt[0]  = '{2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
    vt[1]  = '{2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0};
    vt[2]  = '{2'd2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 16'd0};
    vt[3]  = '{2'd2, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 16'd0};
    vt[4]  = '{2'd2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 16'd0};
    vt[5]  = '{2'd2, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd1};
    vt[6]  = '{2'd2, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'd1};
    vt[7]  = '{2'd2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 16'd1};
    vt[8]  = '{2'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 16'd1};
    vt[9]  = '{2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 16'd2};
    vt[10] = '{2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'd2};

    // Reset values
    do_reset();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_trig", 32'(scan_trigger_o), 32'd0);
    check("rst_count", 32'(scan_count_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_fault", 32'(fault_o), 32'd0);

    // Single-step and ignore rules, one cycle per vector
    for (int i = 0; i < 11; i++) begin
      mode = vt[i].mode; step_req = vt[i].step; man_done = vt[i].done; clr = vt[i].clr;
      tick_n(1);
      check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vt[i].st));
      check($sformatf("vec%0d_trig", i), 32'(scan_trigger_o), 32'(vt[i].trig));
      check($sformatf("vec%0d_count", i), 32'(scan_count_o), 32'(vt[i].cnt));
    end
    step_req = 1'b0; man_done = 1'b0; clr = 1'b0;

    // Reset in the middle of a scan
    mode = 2'd2; step_req = 1'b1;
    tick_n(1);
    step_req = 1'b0;
    check("rstmid_trig_pre", 32'(scan_trigger_o), 32'd1);
    tick_n(1);
    check("rstmid_run_pre", 32'(state_o), 32'd3);
    rst = 1'b1;
    #1;
    check("rstmid_state", 32'(state_o), 32'd0);
    check("rstmid_count", 32'(scan_count_o), 32'd0);
    check("rstmid_trig", 32'(scan_trigger_o), 32'd0);
    do_reset();
    mode = 2'd2; step_req = 1'b1;
    tick_n(1);
    step_req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_trig", 32'(scan_trigger_o), 32'd0);

    // Free-run, period 10, done 3 cycles after trigger
    do_reset();
    load_and_run(24'd10, 3);
    wait_trig(5, 200, "freerun_wait");
    tick_n(5);
    mode = 2'd0;
    tick_n(3);
    if (trig_q.size() >= 5) begin
      check("freerun_first", 32'(trig_q[0] - c0), 32'd11);
      for (int i = 1; i < 5; i++)
        check($sformatf("freerun_interval%0d", i), 32'(trig_q[i] - trig_q[i-1]), 32'd10);
    end
    check("freerun_ntrig", 32'(trig_q.size()), 32'd5);
    check("freerun_count", 32'(scan_count_o), 32'd5);
    check("freerun_overrun", 32'(overrun_o), 32'd0);
    check("freerun_state", 32'(state_o), 32'd0);

    // Overrun: period 4, done 6 cycles after trigger
    do_reset();
    load_and_run(24'd4, 6);
    wait_trig(2, 100, "ovr_wait");
    check("ovr_set", 32'(overrun_o), 32'd1);
    if (trig_q.size() >= 2)
      check("ovr_interval", 32'(trig_q[1] - trig_q[0]), 32'd8);
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    check("ovr_clr", 32'(overrun_o), 32'd0);
    tick_n(2);
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    check("ovr_set_wins", 32'(overrun_o), 32'd1);
    mode = 2'd0;
    tick_n(6);
    check("ovr_count", 32'(scan_count_o), 32'd2);
    check("ovr_idle", 32'(state_o), 32'd0);

    // Watchdog: no done ever
    do_reset();
    load_and_run(24'd10, 0);
    wait_trig(1, 100, "wdog_wait");
    tick_n(9);
    check("wdog_run9_state", 32'(state_o), 32'd3);
    check("wdog_run9_fault", 32'(fault_o), 32'd0);
    tick_n(1);
    check("wdog_fault_state", 32'(state_o), 32'd4);
    check("wdog_fault", 32'(fault_o), 32'd1);
    tick_n(30);
    check("wdog_no_trig", 32'(trig_q.size()), 32'd1);
    check("wdog_stays", 32'(state_o), 32'd4);
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
    check("wdog_clr_state", 32'(state_o), 32'd0);
    check("wdog_clr_fault", 32'(fault_o), 32'd0);
    check("wdog_clr_overrun", 32'(overrun_o), 32'd0);
    tick_n(1);
    check("wdog_rearm", 32'(state_o), 32'd1);

    // Period 0 behaves as 1
    do_reset();
    load_and_run(24'd0, 2);
    wait_trig(2, 50, "p0_wait");
    if (trig_q.size() >= 2) begin
      check("p0_first", 32'(trig_q[0] - c0), 32'd2);
      check("p0_interval", 32'(trig_q[1] - trig_q[0]), 32'd4);
    end

    // scan_count wrap
    do_reset();
    mode = 2'd2;
    force dut.scan_count_q = 16'hFFFF;
    tick_n(1);
    release dut.scan_count_q;
    check("wrap_preset", 32'(scan_count_o), 32'h0000_FFFF);
    step_req = 1'b1;
    tick_n(1);
    step_req = 1'b0;
    tick_n(1);
    man_done = 1'b1;
    tick_n(1);
    man_done = 1'b0;
    check("wrap_count", 32'(scan_count_o), 32'd0);
    check("wrap_state", 32'(state_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
